// File: rtl/rc4_phase_sequencer_pkg.sv
// Shared types and constants for the RC4 key-search phase sequencer.
// The sequencer states and the S-RAM ownership groups live here.
package rc4_pkg;

   localparam int          KEY_W_DEF   = 24;
   localparam int          ADDR_W_DEF  = 8;
   localparam logic [23:0] KEY_MAX_DEF = 24'h3FFFFF;

   typedef enum logic [7:0] {
      IDLE      = 8'd0,
      INIT_GO   = 8'd1,
      INIT_WAIT = 8'd2,
      INIT_ACK  = 8'd3,
      SHA_GO    = 8'd4,
      SHA_WAIT  = 8'd5,
      SHA_ACK   = 8'd6,
      SHB_GO    = 8'd7,
      SHB_WAIT  = 8'd8,
      SHB_ACK   = 8'd9,
      NEXT_KEY  = 8'd10,
      FOUND     = 8'd11,
      EXHAUST   = 8'd12
   } seq_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      INIT = 2'd1,
      SHA  = 2'd2,
      SHB  = 2'd3
   } sram_owner_t;

   // The RAM belongs to a phase for its whole GO/WAIT/ACK window, so a
   // phase may still finish its last write while its ack is in flight.
   function automatic sram_owner_t owner_of(input seq_state_t s);
      sram_owner_t o;
      case (s)
         INIT_GO, INIT_WAIT, INIT_ACK: o = INIT;
         SHA_GO, SHA_WAIT, SHA_ACK:    o = SHA;
         SHB_GO, SHB_WAIT, SHB_ACK:    o = SHB;
         default:                      o = NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/rc4_phase_sequencer_s_ram_mux.sv
// Combinational 3:1 S-RAM port mux; selection comes only from the owner code,
// so an idle controller presents an all-zero, write-disabled port.
module s_ram_mux
   import rc4_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  sram_owner_t       owner_i,
   input  logic [ADDR_W-1:0] addr_init_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [ADDR_W-1:0] addr_b_i,
   input  logic [7:0]        data_init_i,
   input  logic [7:0]        data_a_i,
   input  logic [7:0]        data_b_i,
   input  logic              wren_init_i,
   input  logic              wren_a_i,
   input  logic              wren_b_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [7:0]        data_o,
   output logic              wren_o
);

   always_comb begin
      addr_o = '0;
      data_o = '0;
      wren_o = 1'b0;
      case (owner_i)
         INIT: begin
            addr_o = addr_init_i;
            data_o = data_init_i;
            wren_o = wren_init_i;
         end
         SHA: begin
            addr_o = addr_a_i;
            data_o = data_a_i;
            wren_o = wren_a_i;
         end
         SHB: begin
            addr_o = addr_b_i;
            data_o = data_b_i;
            wren_o = wren_b_i;
         end
         default: begin
            addr_o = '0;
            data_o = '0;
            wren_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 key-search controller: runs S-init, Shuffle A and Shuffle B
// per candidate key, owns the S-RAM port and steps keys until a match.
module rc4_phase_sequencer
   import rc4_pkg::*;
#(
   parameter int                KEY_W   = KEY_W_DEF,
   parameter logic [KEY_W-1:0]  KEY_MAX = KEY_MAX_DEF,
   parameter int                ADDR_W  = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              init_start,
   output logic              shufA_start,
   output logic              shufB_start,
   input  logic              init_finish,
   input  logic              shufA_finish,
   input  logic              shufB_finish,
   output logic              init_ack,
   output logic              shufA_ack,
   output logic              shufB_ack,
   input  logic              msg_ok,
   input  logic [ADDR_W-1:0] addr_init,
   input  logic [ADDR_W-1:0] addr_A,
   input  logic [ADDR_W-1:0] addr_B,
   input  logic [7:0]        data_init,
   input  logic [7:0]        data_A,
   input  logic [7:0]        data_B,
   input  logic              wren_init,
   input  logic              wren_A,
   input  logic              wren_B,
   output logic [ADDR_W-1:0] Address_S,
   output logic [7:0]        data_S,
   output logic              wren_S,
   output logic [KEY_W-1:0]  secret_key,
   output logic              busy,
   output logic              found,
   output logic              exhausted,
   output logic [7:0]        states
);

   localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};

   seq_state_t       state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             msg_ok_q, msg_ok_d;
   logic             init_start_q, shufA_start_q, shufB_start_q;
   logic             init_ack_q, shufA_ack_q, shufB_ack_q;
   logic             busy_q, found_q, exhausted_q;

   // Abort wins over everything; the exhaust test runs before any increment
   // so the key never wraps past KEY_MAX.
   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      msg_ok_d = msg_ok_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, FOUND, EXHAUST: begin
               if (start) begin
                  state_d = INIT_GO;
                  key_d   = '0;
               end
            end
            INIT_GO:   state_d = INIT_WAIT;
            INIT_WAIT: if (init_finish) state_d = INIT_ACK;
            INIT_ACK:  state_d = SHA_GO;
            SHA_GO:    state_d = SHA_WAIT;
            SHA_WAIT:  if (shufA_finish) state_d = SHA_ACK;
            SHA_ACK:   state_d = SHB_GO;
            SHB_GO:    state_d = SHB_WAIT;
            SHB_WAIT: begin
               if (shufB_finish) begin
                  msg_ok_d = msg_ok;
                  state_d  = SHB_ACK;
               end
            end
            SHB_ACK: begin
               if (msg_ok_q)            state_d = FOUND;
               else if (key_q == KEY_MAX) state_d = EXHAUST;
               else                     state_d = NEXT_KEY;
            end
            NEXT_KEY: begin
               key_d   = key_q + KEY_ONE;
               state_d = INIT_GO;
            end
            default:   state_d = IDLE;
         endcase
      end
   end

   // Handshake and status outputs are registered from the next state so they
   // line up exactly with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         key_q         <= '0;
         msg_ok_q      <= 1'b0;
         init_start_q  <= 1'b0;
         shufA_start_q <= 1'b0;
         shufB_start_q <= 1'b0;
         init_ack_q    <= 1'b0;
         shufA_ack_q   <= 1'b0;
         shufB_ack_q   <= 1'b0;
         busy_q        <= 1'b0;
         found_q       <= 1'b0;
         exhausted_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         msg_ok_q      <= msg_ok_d;
         init_start_q  <= (state_d == INIT_GO);
         shufA_start_q <= (state_d == SHA_GO);
         shufB_start_q <= (state_d == SHB_GO);
         init_ack_q    <= (state_d == INIT_ACK);
         shufA_ack_q   <= (state_d == SHA_ACK);
         shufB_ack_q   <= (state_d == SHB_ACK);
         busy_q        <= !(state_d inside {IDLE, FOUND, EXHAUST});
         found_q       <= (state_d == FOUND);
         exhausted_q   <= (state_d == EXHAUST);
      end
   end

   s_ram_mux #(
      .ADDR_W (ADDR_W)
   ) u_s_ram_mux (
      .owner_i     (owner_of(state_q)),
      .addr_init_i (addr_init),
      .addr_a_i    (addr_A),
      .addr_b_i    (addr_B),
      .data_init_i (data_init),
      .data_a_i    (data_A),
      .data_b_i    (data_B),
      .wren_init_i (wren_init),
      .wren_a_i    (wren_A),
      .wren_b_i    (wren_B),
      .addr_o      (Address_S),
      .data_o      (data_S),
      .wren_o      (wren_S)
   );

   assign init_start  = init_start_q;
   assign shufA_start = shufA_start_q;
   assign shufB_start = shufB_start_q;
   assign init_ack    = init_ack_q;
   assign shufA_ack   = shufA_ack_q;
   assign shufB_ack   = shufB_ack_q;
   assign secret_key  = key_q;
   assign busy        = busy_q;
   assign found       = found_q;
   assign exhausted   = exhausted_q;
   assign states      = state_q;

endmodule
